// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared AXI response/burst codes and FSM state encodings
// Contents: RESP_* response codes, BURST_* burst codes, write/read engine state types,
//           and a helper that flags unsupported burst types.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // WRAP (10) and reserved (11) both have bit 1 set; they are answered with SLVERR.
  function automatic logic burst_is_bad(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi_sram_slave_mem.sv
// rtl/axi_sram_slave_mem.sv - 32-bit SRAM array, one byte-masked write port and one sync read port
// Ports: clock_i; we_i/waddr_i/wdata_i/wstrb_i write port; re_i/raddr_i read request;
//        rdata_o registered read data, updated only when re_i is high.
module axi_sram_slave_mem #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clock_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // A write and a read of the same word in one cycle returns the old contents.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 responder over a byte-writable SRAM, independent read/write engines
// Ports: clock, reset (sync, active-high); io_slave_aw*/w*/b* write channels;
//        io_slave_ar*/r* read channels. One outstanding burst per direction, INCR/FIXED up to 256 beats.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int AW = $clog2(MEM_WORDS);

  // ---------------- write engine ----------------
  wr_state_e     wr_state_q;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wlen_q, wcnt_q;
  logic          wfixed_q, wbad_q;
  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic [3:0]    bid_q;
  logic          w_cnt_last, w_final, w_err;

  assign waddr_d    = wfixed_q ? waddr_q : waddr_q + AW'(1);
  assign w_cnt_last = (wcnt_q == wlen_q);
  // The burst ends on whichever comes first: wlast or the beat count; disagreement is an error.
  assign w_final    = io_slave_wlast | w_cnt_last;
  assign w_err      = wbad_q | (io_slave_wlast != w_cnt_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= 4'd0;
      waddr_q    <= '0;
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      wfixed_q   <= 1'b0;
      wbad_q     <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (io_slave_awvalid && awready_q) begin
            waddr_q    <= io_slave_awaddr[AW+1:2];
            bid_q      <= io_slave_awid;
            wlen_q     <= io_slave_awlen;
            wcnt_q     <= 8'd0;
            wfixed_q   <= (io_slave_awburst == BURST_FIXED);
            wbad_q     <= burst_is_bad(io_slave_awburst);
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (io_slave_wvalid) begin
            if (w_final) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= w_err ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
            end else begin
              wcnt_q  <= wcnt_q + 8'd1;
              waddr_q <= waddr_d;
            end
          end
        end
        W_RESP: begin
          if (io_slave_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_e     rd_state_q;
  logic [AW-1:0] raddr_q, raddr_d, mem_raddr;
  logic [7:0]    rlen_q, rcnt_q;
  logic [3:0]    rwait_q;
  logic          rfixed_q, rbad_q;
  logic          arready_q, rvalid_q, rlast_q;
  logic [1:0]    rresp_q;
  logic [3:0]    rid_q;
  logic          mem_re;
  logic [31:0]   mem_rdata;

  // The array is read only when a new beat is loaded, so rdata holds while stalled
  // even if the same word is written meanwhile.
  always_comb begin
    raddr_d   = rfixed_q ? raddr_q : raddr_q + AW'(1);
    mem_re    = 1'b0;
    mem_raddr = raddr_q;
    if (rd_state_q == R_WAIT && rwait_q == 4'd0) begin
      mem_re = 1'b1;
    end else if (rd_state_q == R_DATA && io_slave_rready && !rlast_q) begin
      mem_re    = 1'b1;
      mem_raddr = raddr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rid_q      <= 4'd0;
      raddr_q    <= '0;
      rlen_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      rwait_q    <= 4'd0;
      rfixed_q   <= 1'b0;
      rbad_q     <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (io_slave_arvalid && arready_q) begin
            raddr_q    <= io_slave_araddr[AW+1:2];
            rid_q      <= io_slave_arid;
            rlen_q     <= io_slave_arlen;
            rcnt_q     <= 8'd0;
            rwait_q    <= 4'(RD_LAT);
            rfixed_q   <= (io_slave_arburst == BURST_FIXED);
            rbad_q     <= burst_is_bad(io_slave_arburst);
            arready_q  <= 1'b0;
            rd_state_q <= R_WAIT;
          end
        end
        // With rwait_q at zero this cycle issues the first array read.
        R_WAIT: begin
          if (rwait_q == 4'd0) begin
            rvalid_q   <= 1'b1;
            rlast_q    <= (rlen_q == 8'd0);
            rresp_q    <= rbad_q ? RESP_SLVERR : RESP_OKAY;
            rd_state_q <= R_DATA;
          end else begin
            rwait_q <= rwait_q - 4'd1;
          end
        end
        R_DATA: begin
          if (io_slave_rready) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              rcnt_q  <= rcnt_q + 8'd1;
              raddr_q <= raddr_d;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  axi_sram_slave_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clock_i (clock),
    .we_i    (wready_q & io_slave_wvalid),
    .waddr_i (waddr_q),
    .wdata_i (io_slave_wdata),
    .wstrb_i (io_slave_wstrb),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign io_slave_awready = awready_q;
  assign io_slave_wready  = wready_q;
  assign io_slave_bvalid  = bvalid_q;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_bid     = bid_q;
  assign io_slave_arready = arready_q;
  assign io_slave_rvalid  = rvalid_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rlast   = rlast_q;
  assign io_slave_rid     = rid_q;
  assign io_slave_rdata   = rvalid_q ? mem_rdata : 32'd0;

  // Size is fixed at 4 bytes and address bits outside the word index are dropped.
  logic unused_inputs;
  assign unused_inputs = ^{io_slave_awsize, io_slave_arsize,
                           io_slave_awaddr[31:AW+2], io_slave_awaddr[1:0],
                           io_slave_araddr[31:AW+2], io_slave_araddr[1:0], rcnt_q};

endmodule
